// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
// Start/busy/done handshake; bcd_out holds the last finished result between conversions.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESETb,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [1:0]            fsm_state
);

  // Handshake: start is sampled on a posedge only while busy==0 (IDLE or DONE);
  // that edge captures bin_in. done is a one-cycle pulse meaning bcd_out was just
  // loaded. busy and done are never high together.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t                state;
  logic [WIDTH-1:0]      bin_q;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   corrected;
  logic [4*DIGITS-1:0]   shifted;
  logic [CW-1:0]         count;

  // Add-3 correction on every digit >= 5, then the next binary bit shifts in.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted = {corrected[4*DIGITS-2:0], bin_q[WIDTH-1]};
  end

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      bin_q   <= '0;
      scratch <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bin_q   <= bin_in;
            scratch <= '0;
            count   <= CW'(WIDTH);
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          bin_q   <= {bin_q[WIDTH-2:0], 1'b0};
          count   <= count - CW'(1);
          // Final shift: publish the result directly from the shift path.
          if (count == CW'(1)) begin
            bcd_out <= shifted;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule
